// File: rtl/seq_mult_rr_ctrl_pkg.sv
// seq_mult_pkg: shared definitions for the round-robin multiplier controller.
//   - state_t   : controller FSM encoding (IDLE=0, LOAD=1, RUN=2, DONE=3)
//   - DEF_*     : default sizing used by the controller and its interface
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEF_NREQ     = 4;
  localparam int DEF_WIDTH    = 6;
  localparam int DEF_MULT_LAT = 6;

endpackage

// File: rtl/seq_mult_rr_ctrl_if.sv
// seq_mult_rr_ctrl_if: requester-side bus of the shared multiplier controller.
//   req        : per-requester request level, held with operands until gnt
//   req_a/b    : packed operands, requester i at [i*WIDTH +: WIDTH]
//   gnt        : one-hot pulse, operands of that requester were taken
//   resp_valid : pulse qualifying resp_id / resp_prod
//   resp_id    : requester the result belongs to
//   resp_prod  : unsigned product, held after resp_valid
//   busy       : controller not idle
// master = requester side, slave = controller side.
interface seq_mult_rr_ctrl_if
  import seq_mult_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH
);
  localparam int IDX_W = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       gnt;
  logic                  resp_valid;
  logic [IDX_W-1:0]      resp_id;
  logic [2*WIDTH-1:0]    resp_prod;
  logic                  busy;

  modport master (
    output req, req_a, req_b,
    input  gnt, resp_valid, resp_id, resp_prod, busy
  );

  modport slave (
    input  req, req_a, req_b,
    output gnt, resp_valid, resp_id, resp_prod, busy
  );

endinterface

// File: rtl/seq_mult_rr_ctrl_rr_pick.sv
// rr_pick: combinational round-robin winner selection.
//   req    : request vector
//   ptr    : index of the last winner; search starts at ptr+1 (mod NREQ)
//   onehot : one-hot winner (all zero when no request)
//   idx    : winner index (0 when no request)
//   any    : at least one request present
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic             found;
  logic [IDX_W-1:0] cand;

  // Walk offsets 1..NREQ from the pointer; offset NREQ lands back on the
  // last winner, so it is only chosen when nobody else is asking.
  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    cand   = '0;
    any    = |req;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IDX_W'((int'(ptr) + i) % NREQ);
      if (!found && req[cand]) begin
        found        = 1'b1;
        onehot[cand] = 1'b1;
        idx          = cand;
      end
    end
  end

endmodule

// File: rtl/seq_mult_rr_ctrl.sv
// seq_mult_rr_ctrl: shares one sequential multiplier among NREQ requesters.
//   clk, rst      : clock, synchronous active-low reset
//   bus (slave)   : requester bus (req/operands in, gnt/response out)
//   mult_rst      : active-high multiplier reset, follows ~rst
//   mult_load     : multiplier load strobe (LOAD state)
//   mult_a/mult_b : captured operands, held until the next capture
//   mult_product  : multiplier result, valid MULT_LAT cycles after load
module seq_mult_rr_ctrl
  import seq_mult_pkg::*;
#(
  parameter int NREQ     = DEF_NREQ,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MULT_LAT = DEF_MULT_LAT
) (
  input  logic               clk,
  input  logic               rst,
  seq_mult_rr_ctrl_if.slave  bus,
  output logic               mult_rst,
  output logic               mult_load,
  output logic [WIDTH-1:0]   mult_a,
  output logic [WIDTH-1:0]   mult_b,
  input  logic [2*WIDTH-1:0] mult_product
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(MULT_LAT + 1);

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   ptr_q, win_q, pick_idx;
  logic [NREQ-1:0]    win_oh_q, pick_oh;
  logic               pick_any;
  logic               capture;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] prod_q;

  rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
    .req    (bus.req),
    .ptr    (ptr_q),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // A new operation may only start from IDLE or straight out of DONE.
  assign capture = pick_any && ((state == IDLE) || (state == DONE));

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (capture) state_nxt = LOAD;
      LOAD:    state_nxt = RUN;
      RUN:     if (cnt_q == CNT_W'(1)) state_nxt = DONE;
      DONE:    state_nxt = capture ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Winner, pointer and operands are taken on the edge leaving IDLE/DONE;
  // the pointer moves only when a requester is actually chosen.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q    <= IDX_W'(NREQ - 1);
      win_q    <= '0;
      win_oh_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
    end else begin
      if (capture) begin
        ptr_q    <= pick_idx;
        win_q    <= pick_idx;
        win_oh_q <= pick_oh;
        a_q      <= bus.req_a[pick_idx*WIDTH +: WIDTH];
        b_q      <= bus.req_b[pick_idx*WIDTH +: WIDTH];
      end
      if (state == LOAD)                    cnt_q <= CNT_W'(MULT_LAT);
      else if (state == RUN && cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
      if (state == DONE) prod_q <= mult_product;
    end
  end

  // In DONE the product is passed straight through; afterwards the
  // registered copy keeps resp_prod stable.
  always_comb begin
    bus.gnt        = (state == LOAD) ? win_oh_q : '0;
    mult_load      = (state == LOAD);
    bus.resp_valid = (state == DONE);
    bus.resp_id    = win_q;
    bus.resp_prod  = (state == DONE) ? mult_product : prod_q;
    bus.busy       = (state != IDLE);
  end

  assign mult_rst = ~rst;
  assign mult_a   = a_q;
  assign mult_b   = b_q;

endmodule

// File: tb/tb_seq_mult_rr_ctrl.sv
module tb_seq_mult_rr_ctrl;

  localparam int NREQ     = 4;
  localparam int WIDTH    = 6;
  localparam int MULT_LAT = 6;

  typedef struct {
    logic [1:0]  id;
    logic [11:0] prod;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mult_rst, mult_load;
  logic [5:0]  mult_a, mult_b;
  logic [11:0] mult_product;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  seq_mult_rr_ctrl_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  seq_mult_rr_ctrl #(.NREQ(NREQ), .WIDTH(WIDTH), .MULT_LAT(MULT_LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .mult_rst     (mult_rst),
    .mult_load    (mult_load),
    .mult_a       (mult_a),
    .mult_b       (mult_b),
    .mult_product (mult_product)
  );

  always #5 clk = ~clk;

  // Behavioural sequential multiplier: product valid MULT_LAT cycles after
  // the load edge, a junk value before that.
  logic [5:0] ma = '0, mb = '0;
  int         mcnt = 0;
  bit         mloaded = 1'b0;
  always @(posedge clk) begin
    if (mult_rst) begin
      mcnt    <= 0;
      mloaded <= 1'b0;
    end else if (mult_load) begin
      ma      <= mult_a;
      mb      <= mult_b;
      mcnt    <= MULT_LAT;
      mloaded <= 1'b1;
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
    end
  end
  assign mult_product = (mloaded && mcnt == 0) ? ({6'b0, ma} * {6'b0, mb}) : 12'hA5A;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [5:0] a, input logic [5:0] b);
    bus.req_a[i*WIDTH +: WIDTH] = a;
    bus.req_b[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic do_reset();
    bus.req = '0;
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
  endtask

  task automatic push_exp(input int id, input int a, input int b);
    exp_t e;
    e.id   = 2'(id);
    e.prod = 12'(a * b);
    sb.push_back(e);
  endtask

  task automatic pop_exp(output exp_t e, output bit ok);
    ok = (sb.size() != 0);
    e.id = '0;
    e.prod = '0;
    if (ok) e = sb.pop_front();
  endtask

  task automatic wait_resp(input int maxc, output int n, output bit seen);
    n = 0;
    seen = 1'b0;
    while (!seen && n < maxc) begin
      tick();
      n++;
      seen = bus.resp_valid;
    end
  endtask

  task automatic test_reset();
    bus.req   = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    rst = 1'b0;
    #1;
    vectors++;
    if (mult_rst !== 1'b1) begin miscompares++; $display("FAIL rst_mult_rst: got %b want 1", mult_rst); end
    repeat (2) tick();
    vectors++;
    if ({bus.gnt, bus.resp_valid, bus.resp_id, bus.resp_prod, bus.busy, mult_load, mult_a, mult_b} !== '0) begin
      miscompares++;
      $display("FAIL rst_outputs: gnt=%b rv=%b id=%0d prod=%0d busy=%b load=%b a=%0d b=%0d want all 0",
               bus.gnt, bus.resp_valid, bus.resp_id, bus.resp_prod, bus.busy, mult_load, mult_a, mult_b);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (mult_rst !== 1'b0) begin miscompares++; $display("FAIL rst_release: mult_rst got %b want 0", mult_rst); end
    tick();
  endtask

  task automatic test_single();
    exp_t e; bit ok, seen; int n;
    set_op(0, 6'd63, 6'd62);
    bus.req = 4'b0001;
    push_exp(0, 63, 62);
    tick();
    vectors++;
    if (bus.gnt !== 4'b0001 || mult_load !== 1'b1) begin
      miscompares++; $display("FAIL single_gnt: gnt=%b load=%b want 0001/1", bus.gnt, mult_load);
    end
    vectors++;
    if (mult_a !== 6'd63 || mult_b !== 6'd62) begin
      miscompares++; $display("FAIL single_ops: a=%0d b=%0d want 63/62", mult_a, mult_b);
    end
    bus.req = '0;
    set_op(0, 6'd1, 6'd1);
    wait_resp(20, n, seen);
    vectors++;
    if (!seen || n != 7) begin miscompares++; $display("FAIL single_latency: seen=%b cycles=%0d want 7", seen, n); end
    pop_exp(e, ok);
    vectors++;
    if (!ok || bus.resp_id !== e.id || bus.resp_prod !== e.prod) begin
      miscompares++; $display("FAIL single_resp: id=%0d prod=%0d want %0d/%0d", bus.resp_id, bus.resp_prod, e.id, e.prod);
    end
    tick();
    vectors++;
    if (bus.busy !== 1'b0 || bus.resp_valid !== 1'b0 || bus.resp_prod !== 12'd3906) begin
      miscompares++; $display("FAIL single_idle: busy=%b rv=%b prod=%0d want 0/0/3906", bus.busy, bus.resp_valid, bus.resp_prod);
    end
  endtask

  task automatic test_two();
    exp_t e; bit ok, seen; int n;
    do_reset();
    set_op(0, 6'd5, 6'd7);
    set_op(2, 6'd63, 6'd63);
    bus.req = 4'b0101;
    push_exp(0, 5, 7);
    push_exp(2, 63, 63);
    tick();
    vectors++;
    if (bus.gnt !== 4'b0001) begin miscompares++; $display("FAIL two_gnt0: got %b want 0001", bus.gnt); end
    bus.req[0] = 1'b0;
    wait_resp(20, n, seen);
    pop_exp(e, ok);
    vectors++;
    if (!seen || n != 7 || !ok || bus.resp_id !== e.id || bus.resp_prod !== e.prod) begin
      miscompares++; $display("FAIL two_resp0: cycles=%0d id=%0d prod=%0d want 7/%0d/%0d", n, bus.resp_id, bus.resp_prod, e.id, e.prod);
    end
    tick();
    vectors++;
    if (bus.gnt !== 4'b0100) begin miscompares++; $display("FAIL two_gnt2: got %b want 0100 eight cycles after first", bus.gnt); end
    bus.req = '0;
    wait_resp(20, n, seen);
    pop_exp(e, ok);
    vectors++;
    if (!seen || n != 7 || !ok || bus.resp_id !== e.id || bus.resp_prod !== e.prod) begin
      miscompares++; $display("FAIL two_resp2: cycles=%0d id=%0d prod=%0d want 7/%0d/%0d", n, bus.resp_id, bus.resp_prod, e.id, e.prod);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    exp_t e; bit ok, seen; int n; logic [3:0] exp_oh;
    int av[4], bv[4];
    do_reset();
    for (int i = 0; i < 4; i++) begin
      av[i] = 9 + i * 11;
      bv[i] = 60 - i * 7;
      set_op(i, 6'(av[i]), 6'(bv[i]));
    end
    for (int k = 0; k < 6; k++) push_exp(k % 4, av[k % 4], bv[k % 4]);
    bus.req = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      tick();
      exp_oh = 4'b0001 << (k % 4);
      vectors++;
      if (bus.gnt !== exp_oh) begin miscompares++; $display("FAIL b2b_gnt%0d: got %b want %b", k, bus.gnt, exp_oh); end
      if (k == 5) bus.req = '0;
      wait_resp(20, n, seen);
      pop_exp(e, ok);
      vectors++;
      if (!seen || n != 7 || !ok || bus.resp_id !== e.id || bus.resp_prod !== e.prod) begin
        miscompares++;
        $display("FAIL b2b_resp%0d: cycles=%0d id=%0d prod=%0d want 7/%0d/%0d", k, n, bus.resp_id, bus.resp_prod, e.id, e.prod);
      end
    end
    tick();
    vectors++;
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL b2b_idle: busy=%b want 0", bus.busy); end
  endtask

  task automatic test_zero();
    exp_t e; bit ok, seen; int n;
    set_op(1, 6'd0, 6'd45);
    bus.req = 4'b0010;
    push_exp(1, 0, 45);
    tick();
    vectors++;
    if (bus.gnt !== 4'b0010) begin miscompares++; $display("FAIL zero_gnt: got %b want 0010", bus.gnt); end
    bus.req = '0;
    wait_resp(20, n, seen);
    pop_exp(e, ok);
    vectors++;
    if (!seen || !ok || bus.resp_id !== e.id || bus.resp_prod !== e.prod) begin
      miscompares++; $display("FAIL zero_resp: id=%0d prod=%0d want %0d/%0d", bus.resp_id, bus.resp_prod, e.id, e.prod);
    end
    tick();
  endtask

  task automatic test_reset_midrun();
    exp_t e; bit ok, seen; int n; int stray;
    set_op(0, 6'd33, 6'd44);
    bus.req = 4'b0001;
    tick();
    vectors++;
    if (bus.gnt !== 4'b0001) begin miscompares++; $display("FAIL abort_gnt: got %b want 0001", bus.gnt); end
    bus.req = '0;
    repeat (4) tick();
    rst = 1'b0;
    #1;
    vectors++;
    if (mult_rst !== 1'b1) begin miscompares++; $display("FAIL abort_mult_rst: got %b want 1", mult_rst); end
    tick();
    vectors++;
    if ({bus.gnt, bus.resp_valid, bus.resp_id, bus.resp_prod, bus.busy, mult_load, mult_a, mult_b} !== '0) begin
      miscompares++;
      $display("FAIL abort_outputs: gnt=%b rv=%b id=%0d prod=%0d busy=%b load=%b a=%0d b=%0d want all 0",
               bus.gnt, bus.resp_valid, bus.resp_id, bus.resp_prod, bus.busy, mult_load, mult_a, mult_b);
    end
    tick();
    rst = 1'b1;
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.resp_valid || bus.gnt != '0 || bus.busy) stray++;
    end
    vectors++;
    if (stray != 0) begin miscompares++; $display("FAIL abort_quiet: activity cycles=%0d want 0", stray); end
    set_op(3, 6'd2, 6'd3);
    bus.req = 4'b1000;
    push_exp(3, 2, 3);
    tick();
    vectors++;
    if (bus.gnt !== 4'b1000) begin miscompares++; $display("FAIL abort_new_gnt: got %b want 1000", bus.gnt); end
    bus.req = '0;
    wait_resp(20, n, seen);
    pop_exp(e, ok);
    vectors++;
    if (!seen || n != 7 || !ok || bus.resp_id !== e.id || bus.resp_prod !== e.prod) begin
      miscompares++; $display("FAIL abort_new_resp: cycles=%0d id=%0d prod=%0d want 7/%0d/%0d", n, bus.resp_id, bus.resp_prod, e.id, e.prod);
    end
    tick();
    // Pointer restarted at reset and last winner was 3: requester 0 ranks first.
    set_op(0, 6'd4, 6'd4);
    set_op(3, 6'd5, 6'd5);
    bus.req = 4'b1001;
    push_exp(0, 4, 4);
    tick();
    vectors++;
    if (bus.gnt !== 4'b0001) begin miscompares++; $display("FAIL abort_ptr_gnt: got %b want 0001", bus.gnt); end
    bus.req = '0;
    wait_resp(20, n, seen);
    pop_exp(e, ok);
    vectors++;
    if (!seen || !ok || bus.resp_id !== e.id || bus.resp_prod !== e.prod) begin
      miscompares++; $display("FAIL abort_ptr_resp: id=%0d prod=%0d want %0d/%0d", bus.resp_id, bus.resp_prod, e.id, e.prod);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_two();
    test_back_to_back();
    test_zero();
    test_reset_midrun();
    vectors++;
    if (sb.size() != 0) begin miscompares++; $display("FAIL sb_leftover: got %0d entries want 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
